hme_ip_eth_rx_frame_fifo: RTL and testbench
===========================================

HME_IP_ETH_RX_FRAME_FIFO -- requirements
Module: hme_ip_eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning log2 of store depth in 36-bit entries (512 entries = 2 KB payload).
REQ-002 SHALL have parameter ERR_MASK, default 8'hFF, meaning the rx_status_i bits that mark a frame bad.
REQ-003 SHALL have port clk_app_i  in  1  single clock for all logic; MAC rx stream and application are both synchronous to it.
REQ-004 SHALL have port rst_clk_app_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_valid_i  in  1  MAC rx word valid; no backpressure exists toward the MAC.
REQ-006 SHALL have port rx_data_i  in  32  MAC rx data word.
REQ-007 SHALL have port rx_start_i  in  1  first word of frame, qualified by rx_valid_i.
REQ-008 SHALL have port rx_end_i  in  1  last word of frame, qualified by rx_valid_i.
REQ-009 SHALL have port rx_bytesel_i  in  2  valid bytes in last word (00=4, 01=1, 10=2, 11=3).
REQ-010 SHALL have port rx_status_i  in  8  frame status, sampled with rx_end_i.
REQ-011 SHALL have ports out_valid_o/out_data_o[31:0]/out_start_o/out_end_o/out_bytesel_o[1:0]  out  application stream, same encoding as the rx_* inputs.
REQ-012 SHALL have port out_ready_i  in  1  application accepts the word when out_valid_o and out_ready_i are both high.
REQ-013 SHALL have ports frames_ok_o  out  16 and frames_drop_o  out  16, saturating counters.
REQ-014 SHALL have port fifo_level_o  out  ADDR_W+1  committed entries not yet read.

Function
REQ-015 Write side SHALL be an FSM with states IDLE, RECV and DISCARD.
REQ-016 In IDLE, a valid word with rx_valid_i&rx_start_i SHALL be written at wr_ptr and move the FSM to RECV; valid words without start SHALL be ignored.
REQ-017 In RECV, each valid word SHALL be written and wr_ptr SHALL increment, wrapping modulo 2^ADDR_W; the extra pointer bit SHALL distinguish full from empty.
REQ-018 On rx_end_i with (rx_status_i & ERR_MASK)==0, the FSM SHALL commit: commit_ptr <= wr_ptr+1, frames_ok_o +1, return to IDLE.
REQ-019 On rx_end_i with a masked status bit set, the FSM SHALL roll back: wr_ptr <= commit_ptr, frames_drop_o +1, return to IDLE.
REQ-020 A write attempt while full SHALL roll back wr_ptr, count one drop, and enter DISCARD; DISCARD SHALL ignore words until rx_end_i, then return to IDLE.
REQ-021 rx_start_i received in RECV SHALL abort the current frame (rollback, one drop) and begin the new frame in the same cycle.
REQ-022 Start and end in the same word SHALL form a one-entry frame, committed or dropped per REQ-018/019.
REQ-023 Read side SHALL only read entries below commit_ptr; a partial frame SHALL never be visible.
REQ-024 Output SHALL be a registered stage with one-entry prefetch: out_valid_o rises no later than 2 cycles after commit, and back-to-back words SHALL sustain 1 word/cycle while out_ready_i=1.
REQ-025 out_* data SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-026 Simultaneous commit and read in one cycle SHALL both take effect; fifo_level_o SHALL be commit_ptr - rd_ptr.
REQ-027 Counters SHALL hold at 16'hFFFF.

Reset
REQ-028 When rst_clk_app_n is low, all pointers, the FSM (IDLE), counters and all outputs SHALL be 0 immediately; RAM contents are don't-care.
REQ-029 If reset is released mid-frame, subsequent words SHALL be ignored until the next rx_start_i.

Structure
REQ-030 Package hme_ip_eth_rx_fifo_pkg SHALL hold entry width (36), field bit positions {end,start,bytesel,data}, FSM state enum and the default ERR_MASK.
REQ-031 Storage SHALL be sub-module hme_ip_eth_rx_fifo_ram, a simple dual-port RAM with 1-cycle registered read.

Verification
REQ-032 16-word good frame, status 8'h00, out_ready_i=1 -> 16 words out in order, start on word 0, end on word 15, frames_ok_o=1.
REQ-033 Frame with status 8'h04 at end -> no out_valid_o, frames_drop_o=1, fifo_level_o=0, wr_ptr back at its start value.
REQ-034 ADDR_W=4, 20-word frame -> overflow, DISCARD until end, drop=1; following 3-word good frame fully delivered.
REQ-035 rx_start_i at word 5 of a running frame -> first frame dropped, second frame delivered intact.
REQ-036 out_ready_i toggling 1010..., pointer wrap crossed by 3 consecutive frames -> data bit-exact, out_* stable during stalls.
REQ-037 Reset asserted mid-frame with 2 committed frames pending -> all outputs 0 immediately; after release, idle until next rx_start_i.

Source files
------------

// File: rtl/hme_ip_eth_rx_fifo_pkg.sv
// Shared definitions for the receive frame FIFO: entry layout, write FSM
// states and the saturating counter helper.
package hme_ip_eth_rx_fifo_pkg;

  // Entry layout, MSB to LSB: {end, start, bytesel[1:0], data[31:0]}
  localparam int ENTRY_W   = 36;
  localparam int DATA_LSB  = 0;
  localparam int DATA_MSB  = 31;
  localparam int BSEL_LSB  = 32;
  localparam int BSEL_MSB  = 33;
  localparam int START_BIT = 34;
  localparam int END_BIT   = 35;

  localparam logic [7:0] ERR_MASK_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  // Frame counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] val, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, val} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/hme_ip_eth_rx_fifo_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered output that holds its value while no read is issued.
module hme_ip_eth_rx_fifo_ram
  import hme_ip_eth_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [0:(2**ADDR_W)-1];
  logic [ENTRY_W-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; data is held between reads so a stalled consumer sees it stable.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hme_ip_eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO. A frame becomes readable only after
// its last word arrives with a clean status; bad, aborted or overflowing
// frames are rolled back and never reach the application.
//
// state   | meaning
// IDLE    | waiting for a word carrying rx_start_i
// RECV    | writing words of the current frame, not yet committed
// DISCARD | frame overflowed the store; dropping words until rx_end_i
module hme_ip_eth_rx_frame_fifo
  import hme_ip_eth_rx_fifo_pkg::*;
#(
  parameter int         ADDR_W   = 9,
  parameter logic [7:0] ERR_MASK = ERR_MASK_DEFAULT
) (
  input  logic            clk_app_i,
  input  logic            rst_clk_app_n,
  input  logic            rx_valid_i,
  input  logic [31:0]     rx_data_i,
  input  logic            rx_start_i,
  input  logic            rx_end_i,
  input  logic [1:0]      rx_bytesel_i,
  input  logic [7:0]      rx_status_i,
  output logic            out_valid_o,
  output logic [31:0]     out_data_o,
  output logic            out_start_o,
  output logic            out_end_o,
  output logic [1:0]      out_bytesel_o,
  input  logic            out_ready_i,
  output logic [15:0]     frames_ok_o,
  output logic [15:0]     frames_drop_o,
  output logic [ADDR_W:0] fifo_level_o
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  wr_state_e          state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    base_ptr;
  logic [15:0]        ok_q, ok_d, drop_q, drop_d;
  logic               wr_en, ok_inc, frame_bad;
  logic [1:0]         drop_inc;
  logic [ENTRY_W-1:0] wr_entry, rd_entry, out_entry_q;
  logic               s1_vld_q, out_valid_q, s1_take, rd_en;

  assign frame_bad = |(rx_status_i & ERR_MASK);

  assign wr_entry[DATA_MSB:DATA_LSB] = rx_data_i;
  assign wr_entry[BSEL_MSB:BSEL_LSB] = rx_bytesel_i;
  assign wr_entry[START_BIT]         = rx_start_i;
  assign wr_entry[END_BIT]           = rx_end_i;

  // Write FSM: a start always rebases on commit_ptr, so an aborted frame is
  // rolled back and the new one written in the same cycle.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    base_ptr     = rx_start_i ? commit_ptr_q : wr_ptr_q;
    wr_en        = 1'b0;
    ok_inc       = 1'b0;
    drop_inc     = 2'd0;
    if (rx_valid_i) begin
      case (state_q)
        IDLE, RECV: begin
          if (rx_start_i || (state_q == RECV)) begin
            if (rx_start_i && (state_q == RECV)) drop_inc = 2'd1;
            if ((base_ptr - rd_ptr_q) == DEPTH) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = drop_inc + 2'd1;
              state_d  = rx_end_i ? IDLE : DISCARD;
            end else begin
              wr_en = 1'b1;
              if (!rx_end_i) begin
                wr_ptr_d = base_ptr + PTR_ONE;
                state_d  = RECV;
              end else if (!frame_bad) begin
                wr_ptr_d     = base_ptr + PTR_ONE;
                commit_ptr_d = base_ptr + PTR_ONE;
                ok_inc       = 1'b1;
                state_d      = IDLE;
              end else begin
                wr_ptr_d = commit_ptr_q;
                drop_inc = drop_inc + 2'd1;
                state_d  = IDLE;
              end
            end
          end
        end
        DISCARD: if (rx_end_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ok_d   = sat_add16(ok_q, {1'b0, ok_inc});
  assign drop_d = sat_add16(drop_q, drop_inc);

  // Write-side state, pointers and frame counters.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      ok_q         <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      ok_q         <= ok_d;
      drop_q       <= drop_d;
    end
  end

  hme_ip_eth_rx_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i     (clk_app_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (base_ptr[ADDR_W-1:0]),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_entry)
  );

  // s1 is the RAM read register acting as the prefetch entry; it refills in
  // the same cycle it hands its word to the output register.
  assign s1_take  = s1_vld_q && (!out_valid_q || out_ready_i);
  assign rd_en    = (rd_ptr_q != commit_ptr_q) && (!s1_vld_q || s1_take);
  assign rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // Read pipeline: read pointer, prefetch valid and the registered output word.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      rd_ptr_q    <= '0;
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (rd_en)        s1_vld_q <= 1'b1;
      else if (s1_take) s1_vld_q <= 1'b0;
      if (s1_take) begin
        out_valid_q <= 1'b1;
        out_entry_q <= rd_entry;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_entry_q[DATA_MSB:DATA_LSB];
  assign out_bytesel_o = out_entry_q[BSEL_MSB:BSEL_LSB];
  assign out_start_o   = out_entry_q[START_BIT];
  assign out_end_o     = out_entry_q[END_BIT];
  assign frames_ok_o   = ok_q;
  assign frames_drop_o = drop_q;
  assign fifo_level_o  = commit_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_hme_ip_eth_rx_frame_fifo.sv
// Directed bench for the receive frame FIFO, built with a 16-entry store so
// overflow and pointer wrap are reachable with short frames.
module tb_hme_ip_eth_rx_frame_fifo;

  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_valid, rx_start, rx_end;
  logic [31:0] rx_data;
  logic [1:0] rx_bsel;
  logic [7:0] rx_status;
  logic out_valid, out_start, out_end, out_ready;
  logic [31:0] out_data;
  logic [1:0] out_bsel;
  logic [15:0] frames_ok, frames_drop;
  logic [ADDR_W:0] level;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  logic tog_en = 1'b0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] cur_word;

  always #5 clk = ~clk;

  hme_ip_eth_rx_frame_fifo #(.ADDR_W(ADDR_W), .ERR_MASK(8'hFF)) dut (
    .clk_app_i     (clk),
    .rst_clk_app_n (rst_n),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_start_i    (rx_start),
    .rx_end_i      (rx_end),
    .rx_bytesel_i  (rx_bsel),
    .rx_status_i   (rx_status),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_start_o   (out_start),
    .out_end_o     (out_end),
    .out_bytesel_o (out_bsel),
    .out_ready_i   (out_ready),
    .frames_ok_o   (frames_ok),
    .frames_drop_o (frames_drop),
    .fifo_level_o  (level)
  );

  assign cur_word = {out_end, out_start, out_bsel, out_data};

  // Output monitor on the falling edge: records accepted words, flags any change during a stall.
  initial begin
    logic prev_stall;
    logic [35:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!out_valid || cur_word !== prev_word)) stab_err++;
        if (out_valid && out_ready) got_q.push_back(cur_word);
        prev_stall = out_valid && !out_ready;
        prev_word  = cur_word;
      end
    end
  end

  // out_ready toggler for the stall test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready = ~out_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_word(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] b, input logic [7:0] st);
    rx_valid = 1'b1; rx_data = d; rx_start = s; rx_end = e; rx_bsel = b; rx_status = st;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_start = 1'b0; rx_end = 1'b0; rx_bsel = 2'b00; rx_status = 8'h00;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [1:0] b,
                            input logic [7:0] st);
    for (int i = 0; i < n; i++)
      drive_word(base + 32'(i), i == 0, i == n - 1, (i == n - 1) ? b : 2'b00, st);
  endtask

  task automatic expect_frame(input int n, input logic [31:0] base, input logic [1:0] b);
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == n - 1, i == 0, (i == n - 1) ? b : 2'b00, base + 32'(i)});
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (frames_ok !== 16'd0) begin errors++; $display("FAIL reset_ok: got %0d expected 0", frames_ok); end
    checks++; if (frames_drop !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", frames_drop); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
  endtask

  task automatic test_good_frame();
    got_q.delete(); exp_q.delete();
    expect_frame(16, 32'hA000_0000, 2'b01);
    send_frame(16, 32'hA000_0000, 2'b01, 8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL good_level_full: got %0d expected 16", level); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_latency: got valid %b expected 1", out_valid); end
    repeat (16) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL good_rate: got %0d words after 16 cycles expected 16", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_drained: got valid %b expected 0", out_valid); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== 16'd1) begin errors++; $display("FAIL good_ok: got %0d expected 1", frames_ok); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL good_level: got %0d expected 0", level); end
  endtask

  task automatic test_bad_frame();
    got_q.delete();
    send_frame(5, 32'hB000_0000, 2'b00, 8'h04);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bad_words: got %0d words expected 0", got_q.size()); end
    checks++; if (frames_drop !== 16'd1) begin errors++; $display("FAIL bad_drop: got %0d expected 1", frames_drop); end
    checks++; if (frames_ok !== 16'd1) begin errors++; $display("FAIL bad_ok: got %0d expected 1", frames_ok); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL bad_level: got %0d expected 0", level); end
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    send_frame(20, 32'hD000_0000, 2'b00, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovf_words: got %0d words expected 0", got_q.size()); end
    checks++; if (frames_drop !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", frames_drop); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_level: got %0d expected 0", level); end
    expect_frame(3, 32'hD100_0000, 2'b10);
    send_frame(3, 32'hD100_0000, 2'b10, 8'h00);
    for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_next_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== 16'd2) begin errors++; $display("FAIL ovf_ok: got %0d expected 2", frames_ok); end
  endtask

  task automatic test_restart();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) drive_word(32'hC100_0000 + 32'(i), i == 0, 1'b0, 2'b00, 8'h00);
    expect_frame(4, 32'hC000_0000, 2'b11);
    send_frame(4, 32'hC000_0000, 2'b11, 8'h00);
    for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frames_drop !== 16'd3) begin errors++; $display("FAIL restart_drop: got %0d expected 3", frames_drop); end
    checks++; if (frames_ok !== 16'd3) begin errors++; $display("FAIL restart_ok: got %0d expected 3", frames_ok); end
  endtask

  task automatic test_single_word();
    got_q.delete(); exp_q.delete();
    expect_frame(1, 32'h1234_5678, 2'b01);
    drive_word(32'h1234_5678, 1'b1, 1'b1, 2'b01, 8'h00);
    drive_word(32'h8765_4321, 1'b1, 1'b1, 2'b10, 8'h80);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_word: got %h expected %h", got_q[0], exp_q[0]); end
    end
    checks++; if (frames_ok !== 16'd4) begin errors++; $display("FAIL single_ok: got %0d expected 4", frames_ok); end
    checks++; if (frames_drop !== 16'd4) begin errors++; $display("FAIL single_drop: got %0d expected 4", frames_drop); end
  endtask

  task automatic test_stall_wrap();
    got_q.delete(); exp_q.delete();
    stab_err = 0;
    tog_en = 1'b1;
    expect_frame(6, 32'hE000_0000, 2'b01);
    expect_frame(8, 32'hE100_0000, 2'b10);
    expect_frame(5, 32'hE200_0000, 2'b11);
    send_frame(6, 32'hE000_0000, 2'b01, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    send_frame(8, 32'hE100_0000, 2'b10, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    send_frame(5, 32'hE200_0000, 2'b11, 8'h00);
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    tog_en = 1'b0;
    out_ready = 1'b1;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable stalls expected 0", stab_err); end
    checks++; if (frames_ok !== 16'd7) begin errors++; $display("FAIL stall_ok: got %0d expected 7", frames_ok); end
    checks++; if (frames_drop !== 16'd4) begin errors++; $display("FAIL stall_drop: got %0d expected 4", frames_drop); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    got_q.delete(); exp_q.delete();
    send_frame(3, 32'hF000_0000, 2'b00, 8'h00);
    send_frame(2, 32'hF100_0000, 2'b00, 8'h00);
    drive_word(32'hF200_0000, 1'b1, 1'b0, 2'b00, 8'h00);
    drive_word(32'hF200_0001, 1'b0, 1'b0, 2'b00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending_valid: got %b expected 1", out_valid); end
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL rstmid_pending_level: got %0d expected 3", level); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (cur_word !== 36'h0) begin errors++; $display("FAIL rstmid_word: got %h expected 0", cur_word); end
    checks++; if (frames_ok !== 16'd0) begin errors++; $display("FAIL rstmid_ok: got %0d expected 0", frames_ok); end
    checks++; if (frames_drop !== 16'd0) begin errors++; $display("FAIL rstmid_drop: got %0d expected 0", frames_drop); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level); end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    got_q.delete();
    drive_word(32'hF200_0002, 1'b0, 1'b0, 2'b00, 8'h00);
    drive_word(32'hF200_0003, 1'b0, 1'b1, 2'b01, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_ignored: got %0d words expected 0", got_q.size()); end
    checks++; if (frames_ok !== 16'd0) begin errors++; $display("FAIL rstmid_ok_after: got %0d expected 0", frames_ok); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rstmid_level_after: got %0d expected 0", level); end
    expect_frame(2, 32'hF300_0000, 2'b10);
    send_frame(2, 32'hF300_0000, 2'b10, 8'h00);
    for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_next_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frames_ok !== 16'd1) begin errors++; $display("FAIL rstmid_next_ok: got %0d expected 1", frames_ok); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_start = 1'b0; rx_end = 1'b0;
    rx_data = '0; rx_bsel = 2'b00; rx_status = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_restart();
    test_single_word();
    test_stall_wrap();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
